// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// The producer/bench side uses master; the serializer uses slave.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ser_out,
        output ser_valid,
        output done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out front end: valid/ready word intake, one bit per clock out.
// A word is reloaded on the last bit edge, so streams have no gap.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    piso_serializer_if.slave   bus
);
    localparam int              CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PENULT_CNT = CNT_W'(WIDTH - 2);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] sr_r, sr_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic             ser_out_r, ser_out_next_s;
    logic             ser_valid_r, ser_valid_next_s;
    logic             done_r, done_next_s;
    logic             last_s;
    logic             in_ready_s;
    logic             accept_s;

    function automatic logic first_bit(input logic [WIDTH-1:0] word);
        if (MSB_FIRST) begin
            return word[WIDTH-1];
        end else begin
            return word[0];
        end
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] word);
        if (MSB_FIRST) begin
            return {word[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, word[WIDTH-1:1]};
        end
    endfunction

    // Handshake and next-state/datapath decode
    always_comb begin
        state_next_s     = state_r;
        sr_next_s        = sr_r;
        cnt_next_s       = cnt_r;
        ser_out_next_s   = 1'b0;
        ser_valid_next_s = 1'b0;
        done_next_s      = 1'b0;
        last_s           = (cnt_r == LAST_CNT);
        // rst_n gates ready so nothing can be accepted while reset is held
        in_ready_s       = rst_n && ((state_r == ST_IDLE) || last_s);
        accept_s         = bus.in_valid && in_ready_s;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    sr_next_s        = bus.in_data;
                    ser_out_next_s   = first_bit(bus.in_data);
                    ser_valid_next_s = 1'b1;
                    cnt_next_s       = {CNT_W{1'b0}};
                    state_next_s     = ST_SHIFT;
                end else begin
                    state_next_s     = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!last_s) begin
                    sr_next_s        = shift_word(sr_r);
                    ser_out_next_s   = first_bit(shift_word(sr_r));
                    ser_valid_next_s = 1'b1;
                    cnt_next_s       = cnt_r + CNT_W'(1);
                    done_next_s      = (cnt_r == PENULT_CNT);
                end else if (accept_s) begin
                    sr_next_s        = bus.in_data;
                    ser_out_next_s   = first_bit(bus.in_data);
                    ser_valid_next_s = 1'b1;
                    cnt_next_s       = {CNT_W{1'b0}};
                end else begin
                    cnt_next_s       = {CNT_W{1'b0}};
                    state_next_s     = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, shift register, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sr_r        <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ser_out_r   <= 1'b0;
            ser_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            sr_r        <= sr_next_s;
            cnt_r       <= cnt_next_s;
            ser_out_r   <= ser_out_next_s;
            ser_valid_r <= ser_valid_next_s;
            done_r      <= done_next_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.ser_out   = ser_out_r;
    assign bus.ser_valid = ser_valid_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: W4 LSB-first, W4 MSB-first and W8 MSB-first instances.
module tb_piso_serializer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    piso_serializer_if #(.WIDTH(4)) if_a ();
    piso_serializer_if #(.WIDTH(4)) if_b ();
    piso_serializer_if #(.WIDTH(8)) if_c ();

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        logic [7:0] data;
        int         width;
        logic [7:0] exp_bits;   // exp_bits[k] = bit expected in transmit slot k
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [7:0] data);
        case (d)
            0: begin if_a.in_valid = v; if_a.in_data = data[3:0]; end
            1: begin if_b.in_valid = v; if_b.in_data = data[3:0]; end
            default: begin if_c.in_valid = v; if_c.in_data = data; end
        endcase
    endtask

    task automatic sample(input int d, output logic so, output logic sv,
                          output logic dn, output logic rd);
        case (d)
            0: begin so = if_a.ser_out; sv = if_a.ser_valid; dn = if_a.done; rd = if_a.in_ready; end
            1: begin so = if_b.ser_out; sv = if_b.ser_valid; dn = if_b.done; rd = if_b.in_ready; end
            default: begin so = if_c.ser_out; sv = if_c.ser_valid; dn = if_c.done; rd = if_c.in_ready; end
        endcase
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_idle(input int d, input string tag);
        logic so, sv, dn, rd;
        sample(d, so, sv, dn, rd);
        chk({tag, "_idle_ser_out"}, so, 1'b0);
        chk({tag, "_idle_ser_valid"}, sv, 1'b0);
        chk({tag, "_idle_done"}, dn, 1'b0);
        chk({tag, "_idle_in_ready"}, rd, 1'b1);
    endtask

    // Single isolated word: accept at edge N, bit k visible after edge N+k
    task automatic run_word(input int d, input logic [7:0] data, input int w,
                            input logic [7:0] exp_bits, input string tag);
        logic so, sv, dn, rd;
        drive(d, 1'b1, data);
        tick();
        drive(d, 1'b0, 8'h00);
        for (int k = 0; k < w; k++) begin
            sample(d, so, sv, dn, rd);
            chk($sformatf("%s_b%0d_ser_out", tag, k), so, exp_bits[k]);
            chk($sformatf("%s_b%0d_ser_valid", tag, k), sv, 1'b1);
            chk($sformatf("%s_b%0d_done", tag, k), dn, (k == w - 1));
            chk($sformatf("%s_b%0d_in_ready", tag, k), rd, (k == w - 1));
            tick();
        end
        chk_idle(d, tag);
    endtask

    initial begin
        logic so, sv, dn, rd;
        logic [7:0] seq8;
        checks = 0;
        errors = 0;

        vecs[0] = '{dut: 0, data: 8'h0B, width: 4, exp_bits: 8'h0B}; // 1,1,0,1
        vecs[1] = '{dut: 1, data: 8'h0B, width: 4, exp_bits: 8'h0D}; // 1,0,1,1
        vecs[2] = '{dut: 2, data: 8'hC3, width: 8, exp_bits: 8'hC3}; // 1,1,0,0,0,0,1,1
        vecs[3] = '{dut: 0, data: 8'h08, width: 4, exp_bits: 8'h08}; // 0,0,0,1
        vecs[4] = '{dut: 1, data: 8'h06, width: 4, exp_bits: 8'h06}; // 0,1,1,0
        vecs[5] = '{dut: 2, data: 8'h2D, width: 8, exp_bits: 8'hB4}; // 0,0,1,0,1,1,0,1

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00);
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            sample(d, so, sv, dn, rd);
            chk($sformatf("rst_d%0d_ser_out", d), so, 1'b0);
            chk($sformatf("rst_d%0d_ser_valid", d), sv, 1'b0);
            chk($sformatf("rst_d%0d_done", d), dn, 1'b0);
            chk($sformatf("rst_d%0d_in_ready", d), rd, 1'b0);
        end
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk_idle(d, $sformatf("rel_d%0d", d));
        tick();

        for (int i = 0; i < 6; i++) begin
            run_word(vecs[i].dut, vecs[i].data, vecs[i].width, vecs[i].exp_bits,
                     $sformatf("v%0d", i));
            tick();
        end

        // Back-to-back A then 5, LSB first: 0,1,0,1 then 1,0,1,0 with no gap
        seq8 = 8'b0101_1010;
        drive(0, 1'b1, 8'h0A);
        tick();
        drive(0, 1'b1, 8'h05);
        for (int k = 0; k < 8; k++) begin
            sample(0, so, sv, dn, rd);
            chk($sformatf("b2b_b%0d_ser_out", k), so, seq8[k]);
            chk($sformatf("b2b_b%0d_ser_valid", k), sv, 1'b1);
            chk($sformatf("b2b_b%0d_in_ready", k), rd, (k % 4 == 3));
            chk($sformatf("b2b_b%0d_done", k), dn, (k % 4 == 3));
            if (k == 4) drive(0, 1'b0, 8'h00);
            tick();
        end
        chk_idle(0, "b2b");
        tick();

        // Hold-off: 4'h9 (1,0,0,1) in flight, 4'h3 offered from bit 1 onwards
        seq8 = 8'b0011_1001;
        drive(0, 1'b1, 8'h09);
        tick();
        drive(0, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            sample(0, so, sv, dn, rd);
            chk($sformatf("hold_b%0d_ser_out", k), so, seq8[k]);
            chk($sformatf("hold_b%0d_ser_valid", k), sv, 1'b1);
            chk($sformatf("hold_b%0d_in_ready", k), rd, (k % 4 == 3));
            chk($sformatf("hold_b%0d_done", k), dn, (k % 4 == 3));
            if (k == 0) drive(0, 1'b1, 8'h03);
            if (k == 4) drive(0, 1'b0, 8'h00);
            tick();
        end
        chk_idle(0, "hold");
        tick();

        // Reset mid-word: 4'hF for two bits, then asynchronous abort between edges
        drive(0, 1'b1, 8'h0F);
        tick();
        drive(0, 1'b0, 8'h00);
        sample(0, so, sv, dn, rd);
        chk("abort_b0_ser_out", so, 1'b1);
        tick();
        sample(0, so, sv, dn, rd);
        chk("abort_b1_ser_valid", sv, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        sample(0, so, sv, dn, rd);
        chk("abort_async_ser_out", so, 1'b0);
        chk("abort_async_ser_valid", sv, 1'b0);
        chk("abort_async_done", dn, 1'b0);
        chk("abort_async_in_ready", rd, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        chk_idle(0, "abort_rel");
        run_word(0, 8'h06, 4, 8'h06, "after_abort");   // 0,1,1,0
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
